// File: rtl/core_ctrl_sequencer.sv
// ============================================================================
// Module      : core_ctrl_sequencer
// Description : CPU control sequencer. Micro-cycle FSM, LDM/STM register-list
//               pop and ALU/shifter operand selection. Optional macro
//               CTRL_MUL_WAIT_EN enables the multiply wait state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_ctrl_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception,
  input  logic        shift_by_reg,
  input  logic        ldst,
  input  logic        ldst_writeback,
  input  logic        mul,
  input  logic        mem_ready,
  input  logic        mul_ready,
  input  logic        increment,
  input  logic [15:0] mem_regs,
  input  logic        snd_is_imm,
  input  logic [11:0] data_imm,
  input  logic [5:0]  data_shift_imm,
  input  logic        ra_is_pc,
  input  logic        rb_is_pc,
  input  logic [29:0] pc_visible,
  input  logic [31:0] rd_value_a,
  input  logic [31:0] rd_value_b,
  input  logic [31:0] saved_base,
  output logic [2:0]  cycle,
  output logic [2:0]  next_cycle,
  output logic        stall,
  output logic        pop_valid,
  output logic [3:0]  popped,
  output logic [15:0] next_regs,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [7:0]  shifter_shift
);

  typedef enum logic [2:0] {
    ST_ISSUE             = 3'd0,
    ST_RD_INDIRECT_SHIFT = 3'd1,
    ST_WITH_SHIFT        = 3'd2,
    ST_TRANSFER          = 3'd3,
    ST_BASE_WRITEBACK    = 3'd4,
    ST_EXCEPTION         = 3'd5,
    ST_MUL               = 3'd6
  } state_t;

  localparam logic [31:0] c_FOUR = 32'd4;

  state_t      r_cycle;
  state_t      w_next;
  logic        r_after_shift;
  logic [3:0]  w_pop_idx;
  logic [7:0]  w_shift;
  logic [31:0] w_pc_word;

  assign w_pc_word = {pc_visible, 2'b00};

`ifndef CTRL_MUL_WAIT_EN
  // Multiplies complete in one cycle here, so these inputs have no effect.
  logic w_unused_mul;
  assign w_unused_mul = &{1'b0, mul, mul_ready};
`endif

  // Shift amount feeds the ISSUE decision as well as the shifter.
  always_comb begin
    w_shift = {2'b00, data_shift_imm};
    if (r_cycle == ST_RD_INDIRECT_SHIFT) begin
      w_shift = rd_value_b[7:0];
    end
  end

  always_comb begin
    w_next = ST_ISSUE;
    case (r_cycle)
      ST_ISSUE: begin
        if (exception)              w_next = ST_EXCEPTION;
        else if (shift_by_reg)      w_next = ST_RD_INDIRECT_SHIFT;
        else if (w_shift != 8'd0)   w_next = ST_WITH_SHIFT;
        else if (ldst)              w_next = ST_TRANSFER;
`ifdef CTRL_MUL_WAIT_EN
        else if (mul)               w_next = ST_MUL;
`endif
        else                        w_next = ST_ISSUE;
      end
      ST_RD_INDIRECT_SHIFT: w_next = ST_WITH_SHIFT;
      ST_WITH_SHIFT: begin
        if (ldst)                   w_next = ST_TRANSFER;
`ifdef CTRL_MUL_WAIT_EN
        else if (mul)               w_next = ST_MUL;
`endif
        else                        w_next = ST_ISSUE;
      end
      ST_TRANSFER: begin
        if (!mem_ready || pop_valid) w_next = ST_TRANSFER;
        else if (ldst_writeback)     w_next = ST_BASE_WRITEBACK;
        else                         w_next = ST_ISSUE;
      end
      ST_BASE_WRITEBACK: w_next = ST_ISSUE;
      ST_EXCEPTION:      w_next = ST_ISSUE;
`ifdef CTRL_MUL_WAIT_EN
      ST_MUL:            w_next = mul_ready ? ST_ISSUE : ST_MUL;
`endif
      default:           w_next = ST_ISSUE;
    endcase
  end

  // The flag marks the ISSUE cycle that directly follows a WITH_SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle       <= ST_ISSUE;
      r_after_shift <= 1'b0;
    end else begin
      r_cycle       <= w_next;
      r_after_shift <= (r_cycle == ST_WITH_SHIFT);
    end
  end

  // Last match wins: scan order picks lowest (ascending) or highest bit.
  always_comb begin
    w_pop_idx = 4'd0;
    if (increment) begin
      for (int i = 15; i >= 0; i--) begin
        if (mem_regs[i]) w_pop_idx = 4'(i);
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (mem_regs[i]) w_pop_idx = 4'(i);
      end
    end
  end

  always_comb begin
    alu_a = rd_value_a;
    if (r_cycle == ST_TRANSFER || r_cycle == ST_BASE_WRITEBACK) begin
      alu_a = saved_base;
    end else if (ra_is_pc) begin
      alu_a = w_pc_word;
    end
  end

  always_comb begin
    alu_b = rd_value_b;
    if (r_cycle == ST_TRANSFER || r_cycle == ST_EXCEPTION) begin
      alu_b = c_FOUR;
    end else if (r_cycle == ST_WITH_SHIFT || (r_cycle == ST_ISSUE && r_after_shift)) begin
      alu_b = saved_base;
    end else if (snd_is_imm) begin
      alu_b = {20'd0, data_imm};
    end else if (rb_is_pc) begin
      alu_b = w_pc_word;
    end
  end

  assign cycle         = r_cycle;
  assign next_cycle    = w_next;
  assign stall         = (w_next != ST_ISSUE);
  assign pop_valid     = |mem_regs;
  assign popped        = w_pop_idx;
  assign next_regs     = mem_regs & ~(16'd1 << w_pop_idx);
  assign shifter_shift = w_shift;

endmodule

`default_nettype wire

// File: tb/tb_core_ctrl_sequencer.sv
// ============================================================================
// Module      : tb_core_ctrl_sequencer
// Description : Directed self-checking bench for core_ctrl_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        exception, shift_by_reg, ldst, ldst_writeback, mul;
  logic        mem_ready, mul_ready, increment;
  logic [15:0] mem_regs;
  logic        snd_is_imm;
  logic [11:0] data_imm;
  logic [5:0]  data_shift_imm;
  logic        ra_is_pc, rb_is_pc;
  logic [29:0] pc_visible;
  logic [31:0] rd_value_a, rd_value_b, saved_base;
  logic [2:0]  cycle, next_cycle;
  logic        stall, pop_valid;
  logic [3:0]  popped;
  logic [15:0] next_regs;
  logic [31:0] alu_a, alu_b;
  logic [7:0]  shifter_shift;

  int n_vec = 0;
  int n_err = 0;

  core_ctrl_sequencer dut (
    .clk(clk), .rst(rst), .exception(exception), .shift_by_reg(shift_by_reg),
    .ldst(ldst), .ldst_writeback(ldst_writeback), .mul(mul),
    .mem_ready(mem_ready), .mul_ready(mul_ready), .increment(increment),
    .mem_regs(mem_regs), .snd_is_imm(snd_is_imm), .data_imm(data_imm),
    .data_shift_imm(data_shift_imm), .ra_is_pc(ra_is_pc), .rb_is_pc(rb_is_pc),
    .pc_visible(pc_visible), .rd_value_a(rd_value_a), .rd_value_b(rd_value_b),
    .saved_base(saved_base), .cycle(cycle), .next_cycle(next_cycle),
    .stall(stall), .pop_valid(pop_valid), .popped(popped),
    .next_regs(next_regs), .alu_a(alu_a), .alu_b(alu_b),
    .shifter_shift(shifter_shift)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    exception = 0; shift_by_reg = 0; ldst = 0; ldst_writeback = 0; mul = 0;
    mem_ready = 0; mul_ready = 0; increment = 0; mem_regs = 16'h0;
    snd_is_imm = 0; data_imm = 12'h0; data_shift_imm = 6'h0;
    ra_is_pc = 0; rb_is_pc = 0; pc_visible = 30'h0;
    rd_value_a = 32'h1111_2222; rd_value_b = 32'h0; saved_base = 32'hCAFE_0001;
    tick(); tick();
    #1;
    check("rst_cycle", 32'(cycle), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_pop_valid", 32'(pop_valid), 32'd0);
    check("rst_popped", 32'(popped), 32'd0);
    check("rst_next_regs", 32'(next_regs), 32'd0);
    rst = 1'b0;

    // Register-specified shift: ISSUE -> 1 -> 2 -> 0
    tick();
    shift_by_reg = 1; rd_value_b = 32'h0000_0105;
    #1;
    check("ind_next_from_issue", 32'(next_cycle), 32'd1);
    check("ind_stall_issue", 32'(stall), 32'd1);
    tick();
    shift_by_reg = 0;
    #1;
    check("ind_cycle1", 32'(cycle), 32'd1);
    check("ind_shift_amt", 32'(shifter_shift), 32'h05);
    check("ind_next1", 32'(next_cycle), 32'd2);
    tick();
    check("ind_cycle2", 32'(cycle), 32'd2);
    check("ind_alu_b_shift", alu_b, 32'hCAFE_0001);
    check("ind_next2", 32'(next_cycle), 32'd0);
    check("ind_stall2", 32'(stall), 32'd0);
    tick();
    check("ind_cycle0", 32'(cycle), 32'd0);
    check("ind_alu_b_after_shift", alu_b, 32'hCAFE_0001);
    tick();
    check("ind_alu_b_flag_clear", alu_b, 32'h0000_0105);

    // Operand muxing in ISSUE
    snd_is_imm = 1; data_imm = 12'hFFF; ra_is_pc = 1; pc_visible = 30'h10;
    #1;
    check("imm_alu_b", alu_b, 32'h0000_0FFF);
    check("pc_alu_a", alu_a, 32'h0000_0040);
    snd_is_imm = 0; rb_is_pc = 1;
    #1;
    check("pc_alu_b", alu_b, 32'h0000_0040);
    ra_is_pc = 0; rb_is_pc = 0;
    #1;
    check("reg_alu_a", alu_a, 32'h1111_2222);
    data_shift_imm = 6'h3F;
    #1;
    check("imm_shift_amt", 32'(shifter_shift), 32'h3F);
    check("imm_shift_next", 32'(next_cycle), 32'd2);
    data_shift_imm = 6'h0;

    // LDM ascending with writeback
    ldst = 1; ldst_writeback = 1; increment = 1; mem_regs = 16'h8011;
    mem_ready = 0; saved_base = 32'h0000_1000;
    #1;
    check("ldm_next_issue", 32'(next_cycle), 32'd3);
    tick();
    check("ldm_cycle", 32'(cycle), 32'd3);
    check("ldm_alu_a", alu_a, 32'h0000_1000);
    check("ldm_alu_b", alu_b, 32'd4);
    check("ldm_pop0", 32'(popped), 32'd0);
    check("ldm_next_regs0", 32'(next_regs), 32'h8010);
    mem_ready = 1;
    #1;
    check("ldm_hold_pop", 32'(next_cycle), 32'd3);
    check("ldm_stall", 32'(stall), 32'd1);
    tick();
    mem_regs = 16'h8010;
    #1;
    check("ldm_pop4", 32'(popped), 32'd4);
    check("ldm_next_regs4", 32'(next_regs), 32'h8000);
    tick();
    mem_regs = 16'h8000;
    #1;
    check("ldm_pop15", 32'(popped), 32'd15);
    check("ldm_next_regs15", 32'(next_regs), 32'h0000);
    check("ldm_pop_valid15", 32'(pop_valid), 32'd1);
    tick();
    mem_regs = 16'h0000;
    #1;
    check("ldm_pop_valid_end", 32'(pop_valid), 32'd0);
    check("ldm_popped_empty", 32'(popped), 32'd0);
    check("ldm_next_wb", 32'(next_cycle), 32'd4);
    tick();
    ldst = 0;
    #1;
    check("ldm_cycle_wb", 32'(cycle), 32'd4);
    check("ldm_wb_alu_a", alu_a, 32'h0000_1000);
    check("ldm_wb_next", 32'(next_cycle), 32'd0);
    tick();
    check("ldm_back_issue", 32'(cycle), 32'd0);

    // STMDB descending, no writeback, memory wait
    ldst = 1; ldst_writeback = 0; increment = 0; mem_regs = 16'h0006; mem_ready = 0;
    tick();
    check("stm_cycle", 32'(cycle), 32'd3);
    check("stm_pop2", 32'(popped), 32'd2);
    check("stm_next_regs2", 32'(next_regs), 32'h0002);
    check("stm_wait_next", 32'(next_cycle), 32'd3);
    tick();
    check("stm_wait_hold", 32'(cycle), 32'd3);
    mem_ready = 1; mem_regs = 16'h0002;
    #1;
    check("stm_pop1", 32'(popped), 32'd1);
    check("stm_next_regs1", 32'(next_regs), 32'h0000);
    tick();
    mem_regs = 16'h0000; ldst = 0;
    #1;
    check("stm_cycle_end", 32'(cycle), 32'd3);
    check("stm_next_issue", 32'(next_cycle), 32'd0);
    check("stm_stall_end", 32'(stall), 32'd0);
    tick();
    check("stm_back_issue", 32'(cycle), 32'd0);
    mem_ready = 0;

    // Exception
    exception = 1;
    #1;
    check("exc_next", 32'(next_cycle), 32'd5);
    tick();
    exception = 0;
    #1;
    check("exc_cycle", 32'(cycle), 32'd5);
    check("exc_alu_b", alu_b, 32'd4);
    check("exc_next_issue", 32'(next_cycle), 32'd0);
    tick();
    check("exc_back_issue", 32'(cycle), 32'd0);

    // Multiply
    mul = 1; mul_ready = 0;
    #1;
`ifdef CTRL_MUL_WAIT_EN
    check("mul_next", 32'(next_cycle), 32'd6);
    tick();
    check("mul_cycle_a", 32'(cycle), 32'd6);
    check("mul_stall_a", 32'(stall), 32'd1);
    tick();
    check("mul_cycle_b", 32'(cycle), 32'd6);
    tick();
    check("mul_cycle_c", 32'(cycle), 32'd6);
    mul_ready = 1;
    #1;
    check("mul_done_next", 32'(next_cycle), 32'd0);
    tick();
    check("mul_back_issue", 32'(cycle), 32'd0);
`else
    check("mul_single_next", 32'(next_cycle), 32'd0);
    check("mul_single_stall", 32'(stall), 32'd0);
    tick();
    check("mul_single_cycle", 32'(cycle), 32'd0);
`endif
    mul = 0; mul_ready = 0;

    // Asynchronous reset in the middle of a transfer
    ldst = 1; mem_regs = 16'h0001; mem_ready = 0;
    tick();
    check("rst_mid_cycle_pre", 32'(cycle), 32'd3);
    rst = 1;
    #1;
    check("rst_mid_cycle_async", 32'(cycle), 32'd0);
    ldst = 0; mem_regs = 16'h0000;
    tick();
    rst = 0;
    #1;
    check("rst_mid_stall", 32'(stall), 32'd0);
    tick();
    check("rst_mid_stays_issue", 32'(cycle), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
